// File: rtl/gravsim_pkg.sv
// Shared types for the gravity-simulation controller: datapath opcode and the
// body update scheduler state encoding.
package gravsim_pkg;

   typedef enum logic {
      OP_FORCE = 1'b0,
      OP_INTEG = 1'b1
   } op_kind_t;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ISSUE  = 2'd1,
      S_WAIT   = 2'd2,
      S_FINISH = 2'd3
   } sched_state_t;

endpackage

// File: rtl/body_update_scheduler.sv
// Per-frame sweep of pairwise FORCE ops then per-body INTEG ops over one shared datapath.
// Optional GRAVSIM_OVERRUN_CNT_EN adds the saturating missed-frame counter.
//
// state  | meaning
// IDLE   | waiting for a VS falling edge with run_en high
// ISSUE  | op_valid high, holding op fields until op_ready
// WAIT   | op accepted, waiting for dp_done
// FINISH | sweep complete, frame_done pulse
module body_update_scheduler
   import gravsim_pkg::*;
#(
   parameter int NUM_BODIES = 4,
   parameter int IDX_W      = $clog2(NUM_BODIES)
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             VGA_VS,
   input  logic             run_en,
   input  logic             ovr_clr,
   output logic             op_valid,
   input  logic             op_ready,
   output logic             op_kind,
   output logic [IDX_W-1:0] op_i,
   output logic [IDX_W-1:0] op_j,
   input  logic             dp_done,
   output logic             busy,
   output logic             frame_done,
   output logic             overrun,
   output logic [7:0]       overrun_cnt
);

   localparam int W1 = IDX_W + 1;
   localparam logic [W1-1:0] LAST_IDX = W1'(NUM_BODIES - 1);

   sched_state_t     state_q, state_d;
   op_kind_t         kind_q, kind_d;
   logic [IDX_W-1:0] i_q, i_d, j_q, j_d;
   logic             vs_q, frame_start, ovr_q, ovr_d, ovr_hit;
   logic [W1-1:0]    i_w, j_inc, j_skip;

   assign frame_start = vs_q && !VGA_VS && run_en;

   // One extra bit so the skip-over-diagonal step cannot wrap for N = 16.
   assign i_w    = {1'b0, i_q};
   assign j_inc  = {1'b0, j_q} + W1'(1);
   assign j_skip = (j_inc == i_w) ? j_inc + W1'(1) : j_inc;

   always_comb begin
      state_d = state_q;
      kind_d  = kind_q;
      i_d     = i_q;
      j_d     = j_q;
      ovr_hit = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (frame_start) begin
               state_d = S_ISSUE;
               kind_d  = OP_FORCE;
               i_d     = '0;
               j_d     = IDX_W'(1);
            end
         end
         S_ISSUE: begin
            ovr_hit = frame_start;
            if (op_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            ovr_hit = frame_start;
            if (dp_done) begin
               state_d = S_ISSUE;
               if (kind_q == OP_INTEG) begin
                  if (i_w == LAST_IDX) state_d = S_FINISH;
                  else                 i_d = i_q + IDX_W'(1);
               end else if (j_skip <= LAST_IDX) begin
                  j_d = IDX_W'(j_skip);
               end else if (i_w == LAST_IDX) begin
                  kind_d = OP_INTEG;
                  i_d    = '0;
                  j_d    = '0;
               end else begin
                  i_d = i_q + IDX_W'(1);
                  j_d = '0;
               end
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
            if (frame_start) begin
               state_d = S_ISSUE;
               kind_d  = OP_FORCE;
               i_d     = '0;
               j_d     = IDX_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // A missed frame start outranks a same-cycle clear.
   assign ovr_d = ovr_hit ? 1'b1 : (ovr_clr ? 1'b0 : ovr_q);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= S_IDLE;
         kind_q  <= OP_FORCE;
         i_q     <= '0;
         j_q     <= '0;
         vs_q    <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         kind_q  <= kind_d;
         i_q     <= i_d;
         j_q     <= j_d;
         vs_q    <= VGA_VS;
         ovr_q   <= ovr_d;
      end
   end

   assign op_valid   = (state_q == S_ISSUE);
   assign busy       = (state_q != S_IDLE);
   assign frame_done = (state_q == S_FINISH);
   assign op_kind    = kind_q;
   assign op_i       = i_q;
   assign op_j       = j_q;
   assign overrun    = ovr_q;

`ifdef GRAVSIM_OVERRUN_CNT_EN
   logic [7:0] cnt_q;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)                          cnt_q <= 8'd0;
      else if (ovr_hit && (cnt_q != 8'hFF))  cnt_q <= cnt_q + 8'd1;
   end

   assign overrun_cnt = cnt_q;
`else
   assign overrun_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_body_update_scheduler.sv
// Directed bench for body_update_scheduler (N = 4): sweep order, stalls, overruns,
// mid-sweep reset and run_en gating; follows GRAVSIM_OVERRUN_CNT_EN for count expectations.
module tb_body_update_scheduler;

`ifdef GRAVSIM_OVERRUN_CNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   logic       Clk = 1'b0;
   logic       Reset_n, VGA_VS, run_en, ovr_clr, op_ready, dp_done;
   logic       op_valid, op_kind, busy, frame_done, overrun;
   logic [1:0] op_i, op_j;
   logic [7:0] overrun_cnt;

   int total = 0;
   int bad   = 0;

   // {kind, i, j} for the 16 ops of one N = 4 sweep
   localparam logic [4:0] EXP [16] = '{
      {1'b0, 2'd0, 2'd1}, {1'b0, 2'd0, 2'd2}, {1'b0, 2'd0, 2'd3},
      {1'b0, 2'd1, 2'd0}, {1'b0, 2'd1, 2'd2}, {1'b0, 2'd1, 2'd3},
      {1'b0, 2'd2, 2'd0}, {1'b0, 2'd2, 2'd1}, {1'b0, 2'd2, 2'd3},
      {1'b0, 2'd3, 2'd0}, {1'b0, 2'd3, 2'd1}, {1'b0, 2'd3, 2'd2},
      {1'b1, 2'd0, 2'd0}, {1'b1, 2'd1, 2'd0}, {1'b1, 2'd2, 2'd0},
      {1'b1, 2'd3, 2'd0}
   };

   body_update_scheduler #(.NUM_BODIES(4)) dut (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .VGA_VS      (VGA_VS),
      .run_en      (run_en),
      .ovr_clr     (ovr_clr),
      .op_valid    (op_valid),
      .op_ready    (op_ready),
      .op_kind     (op_kind),
      .op_i        (op_i),
      .op_j        (op_j),
      .dp_done     (dp_done),
      .busy        (busy),
      .frame_done  (frame_done),
      .overrun     (overrun),
      .overrun_cnt (overrun_cnt)
   );

   always #10 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // VS high for one edge then low: the second edge detects the frame start.
   task automatic vs_pulse(input logic exp_valid_after);
      VGA_VS = 1'b1;
      step();
      chk("pre_detect_valid", op_valid, 1'b0);
      VGA_VS = 1'b0;
      step();
      chk("post_detect_valid", op_valid, exp_valid_after);
   endtask

   task automatic run_op(input int idx, input int stall, input bit vs_in_wait, input int exp_cnt);
      int n;
      op_ready = (stall == 0);
      n = 0;
      while (!op_valid && n < 8) begin
         step();
         n++;
      end
      chk($sformatf("op%0d_valid", idx), op_valid, 1'b1);
      chk($sformatf("op%0d_fields", idx), {op_kind, op_i, op_j}, EXP[idx]);
      for (int s = 0; s < stall; s++) begin
         step();
         chk($sformatf("op%0d_stall_valid", idx), op_valid, 1'b1);
         chk($sformatf("op%0d_stall_fields", idx), {op_kind, op_i, op_j}, EXP[idx]);
      end
      op_ready = 1'b1;
      step();
      chk($sformatf("op%0d_accepted", idx), op_valid, 1'b0);
      if (vs_in_wait) VGA_VS = 1'b1;
      step();
      dp_done = 1'b1;
      if (vs_in_wait) VGA_VS = 1'b0;
      step();
      dp_done = 1'b0;
      if (vs_in_wait) begin
         chk("overrun_set", overrun, 1'b1);
         chk("overrun_cnt_wait", overrun_cnt, exp_cnt);
      end
   endtask

   task automatic run_sweep(input int stall_idx, input int vs_idx, input int off_idx);
      vs_pulse(1'b1);
      for (int k = 0; k < 16; k++) begin
         run_op(k, (k == stall_idx) ? 5 : 0, (k == vs_idx), CNT_ON ? 1 : 0);
         if (k == off_idx) run_en = 1'b0;
      end
      chk("frame_done_pulse", frame_done, 1'b1);
      chk("finish_valid", op_valid, 1'b0);
      step();
      chk("frame_done_end", frame_done, 1'b0);
      chk("idle_busy", busy, 1'b0);
   endtask

   initial begin
      Reset_n  = 1'b0;
      VGA_VS   = 1'b0;
      run_en   = 1'b1;
      ovr_clr  = 1'b0;
      op_ready = 1'b1;
      dp_done  = 1'b0;
      step();
      step();
      chk("rst_state", {op_valid, op_kind, op_i, op_j, busy, frame_done, overrun}, 10'd0);
      chk("rst_cnt", overrun_cnt, 8'd0);
      Reset_n = 1'b1;
      step();
      chk("rel_busy", busy, 1'b0);

      // Plain sweep, then a stalled op 3 with run_en dropped mid-sweep.
      run_sweep(-1, -1, -1);
      run_sweep(3, -1, 0);
      chk("run_off_overrun", overrun, 1'b0);
      run_en = 1'b1;

      // Second VS edge during WAIT of op 5.
      run_sweep(-1, 5, -1);
      chk("ovr_still_set", overrun, 1'b1);
      ovr_clr = 1'b1;
      step();
      ovr_clr = 1'b0;
      chk("ovr_cleared", overrun, 1'b0);
      chk("ovr_cnt_kept", overrun_cnt, CNT_ON ? 8'd1 : 8'd0);

      // run_en low across a VS edge; stray dp_done while idle.
      run_en = 1'b0;
      vs_pulse(1'b0);
      step();
      chk("run_off_busy", busy, 1'b0);
      chk("run_off_ovr", overrun, 1'b0);
      dp_done = 1'b1;
      step();
      dp_done = 1'b0;
      step();
      chk("stray_done_busy", busy, 1'b0);
      run_en = 1'b1;

      // Async reset while op 7 is in flight.
      vs_pulse(1'b1);
      for (int k = 0; k < 7; k++) run_op(k, 0, 1'b0, 0);
      chk("op7_fields", {op_kind, op_i, op_j}, EXP[7]);
      step();
      chk("op7_wait_busy", busy, 1'b1);
      #3 Reset_n = 1'b0;
      #1;
      chk("midrst_state", {op_valid, op_kind, op_i, op_j, busy, frame_done, overrun}, 10'd0);
      chk("midrst_cnt", overrun_cnt, 8'd0);
      step();
      Reset_n = 1'b1;
      step();
      chk("post_rst_busy", busy, 1'b0);
      run_sweep(-1, -1, -1);

      // 300 missed frame starts with op 0 held off; clear collides at k = 150.
      op_ready = 1'b0;
      vs_pulse(1'b1);
      for (int k = 0; k < 300; k++) begin
         VGA_VS = 1'b1;
         step();
         VGA_VS = 1'b0;
         if (k == 150) ovr_clr = 1'b1;
         step();
         ovr_clr = 1'b0;
         if (k == 150) chk("ovr_beats_clr", overrun, 1'b1);
      end
      chk("sat_cnt", overrun_cnt, CNT_ON ? 8'd255 : 8'd0);
      chk("sat_ovr", overrun, 1'b1);
      chk("sat_fields", {op_valid, op_kind, op_i, op_j}, {1'b1, EXP[0]});
      ovr_clr = 1'b1;
      step();
      ovr_clr = 1'b0;
      chk("sat_clr", overrun, 1'b0);
      chk("sat_cnt_kept", overrun_cnt, CNT_ON ? 8'd255 : 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
